// File: rtl/alu_seq_ctl.sv
// Multicycle ALU sequencer: latches a request, decodes ALUOp/funct into the
// ALU control code, drives the external combinational ALU for one cycle and
// captures result, zero flag and branch decision.
module alu_seq_ctl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] imm_in,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             br_taken
);

    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlXor = 4'b0101;

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StDone} state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q;
    logic [2:0]       f3_q;
    logic             f7_q;
    logic [WIDTH-1:0] a_q, b_q, imm_q;

    logic [3:0] dec_ctl;
    logic       dec_ill;
    logic       res_zero;
    logic       br_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle:   if (start) state_d = StDecode;
            StDecode: begin
                busy    = 1'b1;
                state_d = dec_ill ? StDone : StExec;
            end
            StExec:   begin
                busy    = 1'b1;
                state_d = StDone;
            end
            StDone:   begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    // Request fields and operands captured only on the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            f3_q  <= '0;
            f7_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
        end else if (state_q == StIdle && start) begin
            op_q  <= alu_op;
            f3_q  <= funct3;
            f7_q  <= funct7_5;
            a_q   <= a_in;
            b_q   <= b_in;
            imm_q <= imm_in;
        end
    end

    // ALUOp/funct decode into ALU control code
    always_comb begin
        dec_ctl = CtlAdd;
        dec_ill = 1'b0;
        unique case (op_q)
            2'b00: dec_ctl = CtlAdd;
            2'b01: begin
                dec_ctl = CtlSub;
                dec_ill = (f3_q != 3'b000) && (f3_q != 3'b001);
            end
            default: begin
                // R-type and I-type share the funct3 map; only R-type honours funct7_5
                unique case (f3_q)
                    3'b000:  dec_ctl = (op_q == 2'b10 && f7_q) ? CtlSub : CtlAdd;
                    3'b111:  dec_ctl = CtlAnd;
                    3'b110:  dec_ctl = CtlOr;
                    3'b100:  dec_ctl = CtlXor;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // ALU drive registers: loaded at the end of DECODE so they are stable through EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctl <= CtlAdd;
            alu_op1 <= '0;
            alu_op2 <= '0;
        end else if (state_q == StDecode && !dec_ill) begin
            alu_ctl <= dec_ctl;
            alu_op1 <= a_q;
            alu_op2 <= (op_q == 2'b11 || op_q == 2'b00) ? imm_q : b_q;
        end
    end

    // Zero flag and branch decision from the returned ALU result
    always_comb begin
        res_zero = (alu_result == '0);
        br_next  = 1'b0;
        if (op_q == 2'b01) br_next = (f3_q == 3'b000) ? res_zero : !res_zero;
    end

    // Result capture at the end of EXEC; illegal requests never reach EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b1;
            br_taken <= 1'b0;
        end else if (state_q == StExec) begin
            result   <= alu_result;
            zero     <= res_zero;
            br_taken <= br_next;
        end
    end

    // Illegal flag: set from decode, cleared when DONE returns to IDLE
    always_ff @(posedge clk) begin
        if (reset)                  illegal <= 1'b0;
        else if (state_q == StDecode) illegal <= dec_ill;
        else if (state_q == StDone)   illegal <= 1'b0;
    end

endmodule

// File: tb/tb_alu_seq_ctl.sv
// Scoreboard bench for alu_seq_ctl: a driver issues requests and queues the
// expected completion; a monitor checks every done pulse against the queue.
module tb_alu_seq_ctl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   alu_op;
    logic [2:0]   funct3;
    logic         funct7_5;
    logic [W-1:0] a_in, b_in, imm_in;
    logic [3:0]   alu_ctl;
    logic [W-1:0] alu_op1, alu_op2, alu_result, result;
    logic         busy, done, illegal, zero, br_taken;

    alu_seq_ctl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .funct3(funct3),
        .funct7_5(funct7_5), .a_in(a_in), .b_in(b_in), .imm_in(imm_in),
        .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .busy(busy), .done(done), .illegal(illegal), .result(result), .zero(zero),
        .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External combinational ALU
    always_comb begin
        case (alu_ctl)
            4'b0010: alu_result = alu_op1 + alu_op2;
            4'b0110: alu_result = alu_op1 - alu_op2;
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 | alu_op2;
            4'b0101: alu_result = alu_op1 ^ alu_op2;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        int           due;
        logic         ill;
        logic [3:0]   ctl;
        logic [W-1:0] res, op1, op2;
        logic         z, br;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;

    // Architectural state the model carries across requests
    logic [W-1:0] m_res, m_op1, m_op2;
    logic [3:0]   m_ctl;
    logic         m_z, m_br;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_z = 1'b1; m_br = 1'b0; m_ctl = 4'b0010; m_op1 = '0; m_op2 = '0;
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_illegal", W'(illegal), 0);
        chk("rst_result", result, 0);
        chk("rst_zero", W'(zero), 1);
        chk("rst_br", W'(br_taken), 0);
        chk("rst_ctl", W'(alu_ctl), W'(4'b0010));
        chk("rst_op1", alu_op1, 0);
        chk("rst_op2", alu_op2, 0);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) v = W'($urandom_range(0, 15));
        return v;
    endfunction

    // Issue one request; while the sequencer is busy, optionally toggle start
    // and scramble the inputs, which must all be ignored.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm, input bit noisy);
        exp_t e;
        logic ill;
        logic [W-1:0] o2, r;
        ill = 1'b0;
        o2  = (op == 2'b00 || op == 2'b11) ? imm : b;
        r   = '0;
        e.ctl = 4'b0010;
        case (op)
            2'b00: begin e.ctl = 4'b0010; r = a + o2; end
            2'b01: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin e.ctl = 4'b0110; r = a - o2; end
                else ill = 1'b1;
            end
            default: begin
                case (f3)
                    3'b000: begin
                        if (op == 2'b10 && f7) begin e.ctl = 4'b0110; r = a - o2; end
                        else begin e.ctl = 4'b0010; r = a + o2; end
                    end
                    3'b111: begin e.ctl = 4'b0000; r = a & o2; end
                    3'b110: begin e.ctl = 4'b0001; r = a | o2; end
                    3'b100: begin e.ctl = 4'b0101; r = a ^ o2; end
                    default: ill = 1'b1;
                endcase
            end
        endcase
        if (!ill) begin
            m_ctl = e.ctl; m_op1 = a; m_op2 = o2; m_res = r; m_z = (r == '0);
            m_br  = (op == 2'b01) ? ((f3 == 3'b000) ? m_z : !m_z) : 1'b0;
        end
        e.ill = ill; e.ctl = m_ctl; e.res = m_res; e.op1 = m_op1; e.op2 = m_op2;
        e.z = m_z; e.br = m_br;

        @(negedge clk);
        start = 1'b1; alu_op = op; funct3 = f3; funct7_5 = f7;
        a_in = a; b_in = b; imm_in = imm;
        @(posedge clk);
        #1;
        e.due = cyc + (ill ? 1 : 2);
        q.push_back(e);
        repeat (ill ? 2 : 3) begin
            @(negedge clk);
            start = noisy ? 1'($urandom) : 1'b0;
            if (noisy) begin
                alu_op = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
                a_in = rnd(); b_in = rnd(); imm_in = rnd();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Monitor: every done must match the head of the scoreboard on the due cycle
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL spurious_done: got done=1 expected no pending request (cycle %0d)",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", W'(cyc), W'(e.due));
                chk("busy_at_done", W'(busy), 1);
                chk("illegal", W'(illegal), W'(e.ill));
                chk("result", result, e.res);
                chk("zero", W'(zero), W'(e.z));
                chk("br_taken", W'(br_taken), W'(e.br));
                chk("alu_ctl", W'(alu_ctl), W'(e.ctl));
                chk("alu_op1", alu_op1, e.op1);
                chk("alu_op2", alu_op2, e.op2);
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            checks++; fails++;
            $display("FAIL missing_done: got no done expected done by cycle %0d (now %0d)",
                     q[0].due, cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; alu_op = '0; funct3 = '0; funct7_5 = 1'b0;
        a_in = '0; b_in = '0; imm_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals();

        // Directed cases
        issue(2'b10, 3'b000, 1'b1, 64'd10, 64'd3, rnd(), 1'b0);
        issue(2'b11, 3'b110, 1'b0, 64'hF0, rnd(), 64'h0F, 1'b0);
        issue(2'b11, 3'b000, 1'b1, '1, rnd(), 64'd1, 1'b0);
        issue(2'b01, 3'b000, 1'b0, 64'd5, 64'd5, rnd(), 1'b0);
        issue(2'b01, 3'b001, 1'b0, 64'd5, 64'd5, rnd(), 1'b0);
        issue(2'b01, 3'b001, 1'b0, 64'd5, 64'd6, rnd(), 1'b0);
        issue(2'b10, 3'b001, 1'b0, rnd(), rnd(), rnd(), 1'b1);
        issue(2'b00, 3'b010, 1'b0, 64'd100, rnd(), 64'd28, 1'b1);
        idle(2);

        // Reset in EXEC: no done, outputs back to reset values, reset beats start
        @(negedge clk);
        start = 1'b1; alu_op = 2'b10; funct3 = 3'b111; a_in = rnd(); b_in = rnd();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        model_reset();
        check_reset_vals();
        idle(3);
        chk("no_accept_under_reset", W'(busy), 0);
        issue(2'b10, 3'b100, 1'b0, 64'hFF00, 64'h0FF0, rnd(), 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            a = rnd();
            b = ($urandom_range(0, 3) == 0) ? a : rnd();
            issue(2'($urandom), 3'($urandom), 1'($urandom), a, b, rnd(),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(8);
        chk("scoreboard_drained", W'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
